fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width in bits, matching the FIFO data port.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning output buffer entries; legal values are 2 to 8.
REQ-003 The block SHALL have parameter CW, default 16, meaning width of the delivered-word counter.
REQ-004 The block SHALL have port rclk, input, 1 bit: the single clock (FIFO read-side clock); all logic is on its rising edge.
REQ-005 The block SHALL have port rrst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port fifo_dout, input, DW bits: FIFO read data, registered inside the FIFO, valid the cycle after a read.
REQ-008 The block SHALL have port fifo_ren, output, 1 bit: FIFO read enable.
REQ-009 The block SHALL have port flush, input, 1 bit: discards all buffered and in-flight words.
REQ-010 The block SHALL have port m_valid, output, 1 bit: downstream stream valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream stream ready.
REQ-012 The block SHALL have port m_data, output, DW bits: downstream stream data.
REQ-013 The block SHALL have port word_cnt, output, CW bits: count of words accepted downstream.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-015 The block SHALL convert the FIFO read port into a valid/ready stream, with a pop defined as m_valid && m_ready.
REQ-016 The block SHALL implement a three-state machine:
- IDLE: no words held. Moves to RUN on fifo_ren.
- RUN: moves to FLUSH on flush; moves to IDLE when buf_count, pend and fifo_ren are all 0.
- FLUSH: moves to IDLE on the first cycle with pend == 0.
REQ-017 fifo_ren SHALL be combinational and equal to !fifo_empty && !flush && state != FLUSH && (buf_count + pend - pop) < DEPTH, using the current-cycle pop.
REQ-018 fifo_ren SHALL never be asserted while fifo_empty is 1.
REQ-019 pend SHALL be a 1-bit register equal to the previous cycle's fifo_ren.
REQ-020 When pend == 1 and the state is RUN, fifo_dout SHALL be written into the buffer tail at the end of that cycle.
REQ-021 Latency SHALL be 2 cycles: fifo_ren asserted in cycle t gives m_valid with that word in cycle t+2 if the buffer was empty.
REQ-022 Sustained throughput SHALL be one word per cycle while the FIFO is non-empty and m_ready is held at 1.
REQ-023 The buffer SHALL be FIFO-ordered, and m_data SHALL be the head entry, driven from a register.
REQ-024 m_valid and m_data SHALL hold stable while m_valid && !m_ready.
REQ-025 A simultaneous write and pop SHALL keep buf_count unchanged.
REQ-026 buf_count SHALL never exceed DEPTH, and buffer overflow SHALL be impossible by construction.
REQ-027 flush in any state SHALL, in the same cycle:
- force fifo_ren to 0;
- clear buf_count and drop m_valid from the next cycle;
- discard the word arriving for any pending read.
REQ-028 A pop coinciding with flush SHALL still count.
REQ-029 word_cnt SHALL increment by 1 on each pop and wrap modulo 2^CW; flush SHALL NOT clear it.

Reset
REQ-030 While rrst is 1, at the next rising edge the block SHALL set: state IDLE, pend 0, buf_count 0, m_valid 0, m_data 0, word_cnt 0, busy 0.
REQ-031 fifo_ren SHALL be 0 during any cycle in which rrst is 1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and pending data, and a FIFO read issued in the reset cycle SHALL NOT occur.
REQ-033 rrst SHALL take priority over flush.

Verification
REQ-034 Reset: hold rrst for 3 cycles while fifo_empty=0 -> fifo_ren, m_valid, word_cnt and busy are all 0 throughout.
REQ-035 Single word: fifo_empty=0 for 1 cycle (t) with fifo_dout=0xA5 at t+1 and m_ready=1 -> fifo_ren=1 at t, m_valid=1 with m_data=0xA5 at t+2, word_cnt=1 at t+3, busy=0 at t+3.
REQ-036 Streaming: FIFO holds 0x01..0x08 and m_ready=1 -> 8 consecutive m_valid cycles with data 0x01..0x08 in order, and word_cnt=8.
REQ-037 Backpressure: stream 0x10..0x1F, holding m_ready=0 for 5 cycles mid-stream -> fifo_ren stops after buf_count+pend reaches 2, m_data is stable throughout, no word is lost or duplicated, and word_cnt=16.
REQ-038 Flush: with buf_count=2 and pend=1, assert flush for 1 cycle -> m_valid=0 the next cycle, the pending word is never output, busy falls within 2 cycles, and the next streamed word appears normally.
REQ-039 Wrap: with CW=4, stream 17 words -> word_cnt reads 1 after the last pop.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Turns a registered-output FIFO read port into a valid/ready stream.
// Reads are issued so that held plus in-flight words never exceed DEPTH.
module fifo_rd_stream #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_ren,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] word_cnt,
    output logic          busy
);

    localparam int NW = $clog2(DEPTH + 1);
    localparam int OW = NW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t        r_state;
    logic          r_pend;
    logic [NW-1:0] r_cnt;
    logic [DW-1:0] r_buf [DEPTH];
    logic [CW-1:0] r_word_cnt;

    logic          w_pop;
    logic          w_wr;
    logic [OW-1:0] w_occ;
    logic [NW-1:0] w_wr_idx;
    logic [NW-1:0] w_cnt_nxt;

    assign w_pop = m_valid && m_ready;

    // Occupancy after this cycle's pop; a pop implies r_cnt >= 1, so no underflow.
    assign w_occ = {1'b0, r_cnt} + OW'(r_pend) - OW'(w_pop);

    assign fifo_ren = !rrst && !fifo_empty && !flush && (r_state != ST_FLUSH)
                      && (w_occ < OW'(DEPTH));

    // The word arriving during a flush cycle is dropped.
    assign w_wr      = r_pend && (r_state == ST_RUN) && !flush;
    assign w_wr_idx  = r_cnt - NW'(w_pop);
    assign w_cnt_nxt = flush ? '0 : (r_cnt + NW'(w_wr) - NW'(w_pop));

    assign m_valid  = (r_cnt != '0);
    assign m_data   = r_buf[0];
    assign word_cnt = r_word_cnt;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state    <= ST_IDLE;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_pend <= fifo_ren;
            r_cnt  <= w_cnt_nxt;
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CW'(1);
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_buf[i] <= r_buf[i + 1];
                end
            end
            // Head is entry 0, so the write lands one slot lower when popping.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr && (w_wr_idx == NW'(i))) begin
                    r_buf[i] <= fifo_dout;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (fifo_ren) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Idle once the buffer drains and nothing is in flight.
                    if (flush)                               r_state <= ST_FLUSH;
                    else if ((w_cnt_nxt == '0) && !fifo_ren) r_state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (!r_pend) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a DEPTH=2/CW=16 and a DEPTH=4/CW=4 instance share
// stimulus, each fed by its own read pointer into one source word list.
module tb_fifo_rd_stream;

    logic        rclk;
    logic        rrst;
    logic        flush;
    logic        m_ready;

    logic        a_empty, a_ren, a_valid, a_busy;
    logic [7:0]  a_dout, a_data;
    logic [15:0] a_cnt;
    logic        b_empty, b_ren, b_valid, b_busy;
    logic [7:0]  b_dout, b_data;
    logic [3:0]  b_cnt;

    fifo_rd_stream #(.DW(8), .DEPTH(2), .CW(16)) dut_a (
        .rclk(rclk), .rrst(rrst), .fifo_empty(a_empty), .fifo_dout(a_dout),
        .fifo_ren(a_ren), .flush(flush), .m_valid(a_valid), .m_ready(m_ready),
        .m_data(a_data), .word_cnt(a_cnt), .busy(a_busy)
    );

    fifo_rd_stream #(.DW(8), .DEPTH(4), .CW(4)) dut_b (
        .rclk(rclk), .rrst(rrst), .fifo_empty(b_empty), .fifo_dout(b_dout),
        .fifo_ren(b_ren), .flush(flush), .m_valid(b_valid), .m_ready(m_ready),
        .m_data(b_data), .word_cnt(b_cnt), .busy(b_busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int nchk = 0;
    int nerr = 0;

    // Source FIFO contents and one read pointer per instance
    logic [7:0] src [1024];
    int         src_len;
    int         rd [2];

    // Reference model: buffer contents, in-flight read, mode, pop count
    logic [7:0]  mb [2][8];
    int          ml [2];
    bit          mpend [2];
    int          mst [2];          // 0 idle, 1 streaming, 2 flushing
    int unsigned mcnt [2];
    int          dep [2];
    int unsigned cmask [2];
    bit          chk_on;

    // Words actually delivered by each instance
    logic [7:0] plog [2][64];
    int         pn [2];
    int         run_cur, run_max;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_flags();
        a_empty = (rd[0] >= src_len);
        b_empty = (rd[1] >= src_len);
    endtask

    task automatic push(input logic [7:0] v);
        src[src_len] = v;
        src_len++;
        set_flags();
    endtask

    task automatic clear_logs();
        pn[0] = 0; pn[1] = 0; run_cur = 0; run_max = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ml[i] = 0; mpend[i] = 1'b0; mst[i] = 0; mcnt[i] = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit f, input bit rdy);
        bit         eren [2];
        bit         epop [2];
        logic       o_ren [2], o_vld [2], o_busy [2];
        logic [7:0] o_data [2];
        int unsigned o_cnt [2];
        logic [7:0] din [2];
        rrst = r; flush = f; m_ready = rdy;
        #1;
        o_ren[0] = a_ren;   o_ren[1] = b_ren;
        o_vld[0] = a_valid; o_vld[1] = b_valid;
        o_data[0] = a_data; o_data[1] = b_data;
        o_busy[0] = a_busy; o_busy[1] = b_busy;
        o_cnt[0] = 32'(a_cnt); o_cnt[1] = 32'(b_cnt);
        din[0] = a_dout; din[1] = b_dout;
        for (int i = 0; i < 2; i++) begin
            epop[i] = (ml[i] > 0) && rdy;
            eren[i] = !r && !f && (mst[i] != 2) && (rd[i] < src_len)
                      && ((ml[i] + int'(mpend[i]) - int'(epop[i])) < dep[i]);
            if (chk_on) begin
                chk($sformatf("ren%0d", i), 32'(o_ren[i]), 32'(eren[i]));
                chk($sformatf("valid%0d", i), 32'(o_vld[i]), 32'(ml[i] > 0));
                if (ml[i] > 0) chk($sformatf("data%0d", i), 32'(o_data[i]), 32'(mb[i][0]));
                chk($sformatf("cnt%0d", i), o_cnt[i], mcnt[i] & cmask[i]);
                chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(mst[i] != 0));
            end
            if (o_vld[i] && rdy && pn[i] < 64) begin
                plog[i][pn[i]] = o_data[i];
                pn[i]++;
            end
        end
        if (a_valid) begin
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
        end else begin
            run_cur = 0;
        end
        @(posedge rclk);
        #1;
        if (o_ren[0] && rd[0] < src_len) begin a_dout = src[rd[0]]; rd[0]++; end
        if (o_ren[1] && rd[1] < src_len) begin b_dout = src[rd[1]]; rd[1]++; end
        set_flags();
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                ml[i] = 0; mpend[i] = 1'b0; mst[i] = 0; mcnt[i] = 0;
            end else begin
                if (epop[i]) mcnt[i]++;
                if (f) begin
                    ml[i] = 0;
                end else begin
                    if (epop[i]) begin
                        for (int j = 0; j < 7; j++) mb[i][j] = mb[i][j + 1];
                        ml[i]--;
                    end
                    if (mpend[i] && mst[i] == 1 && ml[i] < 8) begin
                        mb[i][ml[i]] = din[i];
                        ml[i]++;
                    end
                end
                case (mst[i])
                    0: if (eren[i]) mst[i] = 1;
                    1: if (f) mst[i] = 2; else if (ml[i] == 0 && !eren[i]) mst[i] = 0;
                    default: if (!mpend[i]) mst[i] = 0;
                endcase
                mpend[i] = eren[i];
                if (chk_on) chk($sformatf("bound%0d", i), 32'(ml[i] <= dep[i]), 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        src_len = 0; rd[0] = 0; rd[1] = 0;
        set_flags();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        clear_logs();
    endtask

    typedef struct {
        bit         rst;
        bit         fl;
        bit         rdy;
        bit         ren;
        bit         vld;
        logic [7:0] data;
        logic [15:0] cnt;
        bit         busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        dep[0] = 2;          dep[1] = 4;
        cmask[0] = 32'hFFFF; cmask[1] = 32'hF;
        src_len = 0; rd[0] = 0; rd[1] = 0;
        a_dout = 8'h00; b_dout = 8'h00;
        set_flags();
        clear_logs();
        model_reset();
        chk_on = 1'b0;
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        @(posedge rclk);
        #1;
        chk_on = 1'b1;

        // Reset held with a non-empty FIFO, then a single word 0xA5
        tbl[0] = '{1, 0, 1, 0, 0, 8'h00, 16'd0, 0};
        tbl[1] = '{1, 0, 1, 0, 0, 8'h00, 16'd0, 0};
        tbl[2] = '{1, 0, 1, 0, 0, 8'h00, 16'd0, 0};
        tbl[3] = '{0, 0, 1, 1, 0, 8'h00, 16'd0, 0};
        tbl[4] = '{0, 0, 1, 0, 0, 8'h00, 16'd0, 1};
        tbl[5] = '{0, 0, 1, 0, 1, 8'hA5, 16'd0, 1};
        tbl[6] = '{0, 0, 1, 0, 0, 8'h00, 16'd1, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 8'h00, 16'd1, 0};
        push(8'hA5);
        for (int k = 0; k < 8; k++) begin
            rrst = tbl[k].rst; flush = tbl[k].fl; m_ready = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_ren", k), 32'(a_ren), 32'(tbl[k].ren));
            chk($sformatf("tbl%0d_valid", k), 32'(a_valid), 32'(tbl[k].vld));
            if (tbl[k].vld) chk($sformatf("tbl%0d_data", k), 32'(a_data), 32'(tbl[k].data));
            chk($sformatf("tbl%0d_cnt", k), 32'(a_cnt), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_busy", k), 32'(a_busy), 32'(tbl[k].busy));
            cycle(tbl[k].rst, tbl[k].fl, tbl[k].rdy);
        end

        // Streaming 0x01..0x08 with m_ready held high
        do_reset();
        for (int k = 1; k <= 8; k++) push(8'(k));
        for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0, 1'b1);
        chk("stream_n", 32'(pn[0]), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("stream_w%0d", k), 32'(plog[0][k]), 32'(k + 1));
        chk("stream_run", 32'(run_max), 32'd8);
        chk("stream_cnt", 32'(a_cnt), 32'd8);

        // Backpressure: 0x10..0x1F with a 5-cycle stall mid-stream
        do_reset();
        for (int k = 0; k < 16; k++) push(8'(8'h10 + k));
        for (int k = 0; k < 6; k++)  cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++)  cycle(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) cycle(1'b0, 1'b0, 1'b1);
        chk("bp_n", 32'(pn[0]), 32'd16);
        for (int k = 0; k < 16; k++) chk($sformatf("bp_w%0d", k), 32'(plog[0][k]), 32'(8'h10 + k));
        chk("bp_cnt", 32'(a_cnt), 32'd16);
        chk("bp_cnt4", 32'(b_cnt), 32'd0);

        // Flush while the DEPTH=4 instance holds two words with a third in flight
        do_reset();
        for (int k = 0; k < 16; k++) push(8'(8'h40 + k));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("fl_valid_b", 32'(b_valid), 32'd0);
        chk("fl_valid_a", 32'(a_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("fl_busy_b", 32'(b_busy), 32'd0);
        for (int k = 0; k < 24; k++) cycle(1'b0, 1'b0, 1'b1);
        chk("fl_first_b", 32'(plog[1][0]), 32'h43);
        chk("fl_n_b", 32'(pn[1]), 32'd13);
        chk("fl_first_a", 32'(plog[0][0]), 32'h42);
        chk("fl_n_a", 32'(pn[0]), 32'd14);

        // Counter wrap: 17 words through the CW=4 instance
        do_reset();
        for (int k = 0; k < 17; k++) push(8'(8'h60 + k));
        for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 1'b1);
        chk("wrap_cnt4", 32'(b_cnt), 32'd1);
        chk("wrap_cnt16", 32'(a_cnt), 32'd17);
        chk("wrap_n", 32'(pn[1]), 32'd17);

        // Randomised traffic checked cycle by cycle against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if (src_len < 1000 && $urandom_range(0, 2) != 0) push(8'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
